// File: rtl/fifo_ctrl.sv
// FIFO pointer, occupancy and status controller for an external
// dual-port memory with registered read data.
module fifo_ctrl #(
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = 6,
    parameter  int AE_LEVEL = 2,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic          flush_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_rd_addr_o,
    output logic          rd_valid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rd_valid;
    logic          overflow;
    logic          underflow;
    logic          wr_acc;
    logic          rd_acc;

    assign full_o         = (count == CW'(DEPTH));
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= CW'(AF_LEVEL));
    assign almost_empty_o = (count <= CW'(AE_LEVEL));

    // Gated by rst_n so the memory is never written while reset is held.
    assign wr_acc = rst_n & wr_en_i & ~full_o & ~flush_i;
    assign rd_acc = rst_n & rd_en_i & ~empty_o & ~flush_i;

    assign mem_we_o      = wr_acc;
    assign mem_re_o      = rd_acc;
    assign mem_wr_addr_o = wr_ptr;
    assign mem_rd_addr_o = rd_ptr;
    assign count_o       = count;
    assign rd_valid_o    = rd_valid;
    assign overflow_o    = overflow;
    assign underflow_o   = underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (rd_acc && !wr_acc)
                count <= count - 1'b1;
            rd_valid  <= rd_acc;
            overflow  <= overflow | (wr_en_i & full_o);
            underflow <= underflow | (rd_en_i & empty_o);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: occupancy model plus a data
// scoreboard over a behavioural memory attached to the controller.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, flush;
    logic       mem_we, mem_re, rd_valid;
    logic [2:0] wr_addr, rd_addr;
    logic       full, empty, afull, aempty;
    logic [3:0] count;
    logic       ovf, unf;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [8];
    logic [7:0] rdata;
    logic [7:0] wdata;
    logic [7:0] data_q[$];
    logic [7:0] exp_rd[$];

    int         m_cnt;
    logic [2:0] m_wp, m_rp;
    logic       m_ovf, m_unf;
    logic       m_wa, m_ra;

    always #5 clk = ~clk;

    fifo_ctrl #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en_i(wr_en),
        .rd_en_i(rd_en),
        .flush_i(flush),
        .mem_we_o(mem_we),
        .mem_wr_addr_o(wr_addr),
        .mem_re_o(mem_re),
        .mem_rd_addr_o(rd_addr),
        .rd_valid_o(rd_valid),
        .full_o(full),
        .empty_o(empty),
        .almost_full_o(afull),
        .almost_empty_o(aempty),
        .count_o(count),
        .overflow_o(ovf),
        .underflow_o(unf)
    );

    // Behavioural memory with registered read data.
    always @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= wdata;
        if (mem_re) rdata <= mem[rd_addr];
    end

    // Scoreboard: every rd_valid must carry the oldest pushed word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            tests++;
            if (exp_rd.size() == 0) begin
                fails++;
                $display("FAIL rd_valid_unexpected: got 1 expected 0");
            end else begin
                logic [7:0] e;
                e = exp_rd.pop_front();
                if (rdata !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %0h expected %0h", rdata, e);
                end
            end
        end
    end

    task automatic model_clear();
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
        data_q.delete();
        exp_rd.delete();
    endtask

    // Drive inputs just after a falling edge and let combinational outputs settle.
    task automatic drive(input logic w, input logic r, input logic f);
        wr_en = w; rd_en = r; flush = f;
        wdata = 8'($urandom);
        m_wa = w && m_cnt != 8 && !f;
        m_ra = r && m_cnt != 0 && !f;
        #1;
    endtask

    // Advance the model with the driven inputs, then cross one rising edge.
    task automatic tick();
        if (flush) begin
            model_clear();
        end else begin
            if (wr_en && m_cnt == 8) m_ovf = 1;
            if (rd_en && m_cnt == 0) m_unf = 1;
            if (m_wa) begin data_q.push_back(wdata); m_wp++; end
            if (m_ra) begin exp_rd.push_back(data_q.pop_front()); m_rp++; end
            m_cnt = m_cnt + int'(m_wa) - int'(m_ra);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; wr_en = 1; rd_en = 1; flush = 0; wdata = 0;
        model_clear();
        #3;
        tests++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
            fails++;
            $display("FAIL reset_mem_en: got we=%b re=%b expected 0 0", mem_we, mem_re);
        end
        @(negedge clk);
        rst_n = 1; wr_en = 0; rd_en = 0;
        #1;
        tests++;
        if (count !== 4'd0 || empty !== 1'b1 || aempty !== 1'b1 ||
            full !== 1'b0 || afull !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b expected 0 1 1 0 0",
                     count, empty, aempty, full, afull);
        end
        tests++;
        if (ovf !== 1'b0 || unf !== 1'b0 || rd_valid !== 1'b0 ||
            wr_addr !== 3'd0 || rd_addr !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got ovf=%b unf=%b rv=%b wa=%0d ra=%0d expected all 0",
                     ovf, unf, rd_valid, wr_addr, rd_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0);
            tests++;
            if (mem_we !== 1'b1 || wr_addr !== 3'(i)) begin
                fails++;
                $display("FAIL fill_write: got we=%b addr=%0d expected 1 %0d", mem_we, wr_addr, i);
            end
            tick();
            tests++;
            if (count !== 4'(i + 1) || afull !== (i + 1 >= 6) ||
                aempty !== (i + 1 <= 2) || full !== (i + 1 == 8)) begin
                fails++;
                $display("FAIL fill_status: got cnt=%0d af=%b ae=%b f=%b at push %0d",
                         count, afull, aempty, full, i);
            end
        end
    endtask

    task automatic test_overflow_pop();
        drive(1, 1, 0);
        tests++;
        if (mem_we !== 1'b0 || mem_re !== 1'b1) begin
            fails++;
            $display("FAIL full_push_pop: got we=%b re=%b expected 0 1", mem_we, mem_re);
        end
        tick();
        tests++;
        if (ovf !== 1'b1 || count !== 4'd7) begin
            fails++;
            $display("FAIL overflow: got ovf=%b cnt=%0d expected 1 7", ovf, count);
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 0);
            tests++;
            if (mem_re !== 1'b1 || rd_addr !== m_rp) begin
                fails++;
                $display("FAIL drain_read: got re=%b addr=%0d expected 1 %0d", mem_re, rd_addr, m_rp);
            end
            tick();
        end
        tests++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty: got cnt=%0d e=%b expected 0 1", count, empty);
        end
    endtask

    task automatic test_underflow();
        drive(1, 1, 0);
        tests++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0) begin
            fails++;
            $display("FAIL empty_push_pop: got we=%b re=%b expected 1 0", mem_we, mem_re);
        end
        tick();
        tests++;
        if (unf !== 1'b1 || count !== 4'd1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL underflow: got unf=%b cnt=%0d rv=%b expected 1 1 0", unf, count, rd_valid);
        end
        drive(0, 0, 1);
        tick();
        tests++;
        if (unf !== 1'b0 || count !== 4'd0 || wr_addr !== 3'd0) begin
            fails++;
            $display("FAIL underflow_flush: got unf=%b cnt=%0d wa=%0d expected 0 0 0", unf, count, wr_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic       w_wrap, r_wrap;
        logic [2:0] pw, pr;
        w_wrap = 0; r_wrap = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            pw = wr_addr; pr = rd_addr;
            drive(1, 1, 0);
            tests++;
            if (mem_we !== 1'b1 || mem_re !== 1'b1 ||
                wr_addr !== m_wp || rd_addr !== m_rp) begin
                fails++;
                $display("FAIL b2b_addr: got we=%b re=%b wa=%0d ra=%0d expected 1 1 %0d %0d",
                         mem_we, mem_re, wr_addr, rd_addr, m_wp, m_rp);
            end
            tick();
            if (pw == 3'd7 && wr_addr == 3'd0) w_wrap = 1;
            if (pr == 3'd7 && rd_addr == 3'd0) r_wrap = 1;
            tests++;
            if (count !== 4'd4 || rd_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_count: got cnt=%0d rv=%b expected 4 1", count, rd_valid);
            end
        end
        tests++;
        if (w_wrap !== 1'b1 || r_wrap !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wrap: got w=%b r=%b expected 1 1", w_wrap, r_wrap);
        end
    endtask

    task automatic test_flush();
        drive(0, 0, 1);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0);
            tick();
        end
        tests++;
        if (count !== 4'd5 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL flush_setup: got cnt=%0d ovf=%b expected 5 1", count, ovf);
        end
        drive(1, 0, 1);
        tests++;
        if (mem_we !== 1'b0) begin
            fails++;
            $display("FAIL flush_we: got %b expected 0", mem_we);
        end
        tick();
        tests++;
        if (count !== 4'd0 || empty !== 1'b1 || ovf !== 1'b0 ||
            wr_addr !== 3'd0 || rd_addr !== 3'd0) begin
            fails++;
            $display("FAIL flush_state: got cnt=%0d e=%b ovf=%b wa=%0d ra=%0d expected 0 1 0 0 0",
                     count, empty, ovf, wr_addr, rd_addr);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            tick();
        end
        tests++;
        if (count !== 4'd3) begin
            fails++;
            $display("FAIL areset_setup: got cnt=%0d expected 3", count);
        end
        #2 rst_n = 0;
        #1;
        tests++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL areset_immediate: got cnt=%0d e=%b expected 0 1", count, empty);
        end
        model_clear();
        #1 rst_n = 1;
        @(negedge clk);
        drive(1, 0, 0);
        tests++;
        if (mem_we !== 1'b1 || wr_addr !== 3'd0) begin
            fails++;
            $display("FAIL areset_push: got we=%b addr=%0d expected 1 0", mem_we, wr_addr);
        end
        tick();
        tests++;
        if (count !== 4'd1) begin
            fails++;
            $display("FAIL areset_count: got cnt=%0d expected 1", count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_pop();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        drive(0, 1, 0);
        tick();
        @(negedge clk);
        tests++;
        if (exp_rd.size() != 0) begin
            fails++;
            $display("FAIL rd_missing: got %0d pending expected 0", exp_rd.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
